// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan controller: display codes, segment patterns, FSM states.
// Segment bytes are active-low {dp,g,f,e,d,c,b,a}.
package seg7_pkg;

  localparam logic [4:0] CODE_BLANK = 5'h10;
  localparam logic [4:0] CODE_DASH  = 5'h11;

  localparam logic [7:0] SEG_OFF  = 8'hFF;
  localparam logic [7:0] SEG_DASH = 8'hBF;

  localparam logic [7:0] HEX_SEG [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0,
    8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83,
    8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  typedef enum logic {
    ST_GUARD = 1'b0,
    ST_SCAN  = 1'b1
  } scan_state_t;

endpackage

// File: rtl/seg7_decode.sv
// Combinational display-code decoder: 5-bit code -> blank flag plus active-low segment byte.
// Codes 0x12-0x1F decode the same as CODE_BLANK.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [4:0] code,
  output logic       blank,
  output logic [7:0] seg_n
);

  always_comb begin
    blank = 1'b1;
    seg_n = SEG_OFF;
    if (code[4] == 1'b0) begin
      blank = 1'b0;
      seg_n = HEX_SEG[code[3:0]];
    end else if (code == CODE_DASH) begin
      blank = 1'b0;
      seg_n = SEG_DASH;
    end
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Six-input 7-segment scan scheduler: per-digit dwell slot, optional all-off guard gap,
// per-frame code snapshot. Optional brightness gating under `SEG7_SCAN_DIMMING_EN.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int unsigned D     = 6,
  parameter int unsigned DWELL = 50_000,
  parameter int unsigned GUARD = 500
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [4:0]   in0,
  input  logic [4:0]   in1,
  input  logic [4:0]   in2,
  input  logic [4:0]   in3,
  input  logic [4:0]   in4,
  input  logic [4:0]   in5,
  input  logic [2:0]   bright,
  output logic [D-1:0] an_n,
  output logic [7:0]   seg_n,
  output logic         frame_tick
);

  localparam int unsigned CNT_MAX = (DWELL > GUARD) ? DWELL : GUARD;
  localparam int unsigned CW      = $clog2(CNT_MAX);
  localparam int unsigned IW      = (D > 1) ? $clog2(D) : 1;

  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
  localparam logic [CW-1:0] GUARD_LAST = CW'((GUARD > 0) ? GUARD - 1 : 0);
  localparam logic [IW-1:0] IDX_LAST   = IW'(D - 1);

  scan_state_t   state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [IW-1:0] idx, idx_nx;
  logic          snap;

  logic [4:0]    in_vec [8];
  logic [4:0]    shadow [D];
  logic [2:0]    in_sel;
  logic [4:0]    code_nx;
  logic          blank_nx;
  logic [7:0]    seg_nx;
  logic          in_window;
  logic          lit_nx;

  always_comb begin
    in_vec[0] = in0;
    in_vec[1] = in1;
    in_vec[2] = in2;
    in_vec[3] = in3;
    in_vec[4] = in4;
    in_vec[5] = in5;
    in_vec[6] = CODE_BLANK;
    in_vec[7] = CODE_BLANK;
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt + 1'b1;
    idx_nx   = idx;
    unique case (state)
      ST_GUARD: begin
        if (GUARD == 0 || cnt == GUARD_LAST) begin
          state_nx = ST_SCAN;
          cnt_nx   = '0;
        end
      end
      ST_SCAN: begin
        if (cnt == DWELL_LAST) begin
          cnt_nx   = '0;
          idx_nx   = (idx == IDX_LAST) ? '0 : idx + 1'b1;
          state_nx = (GUARD == 0) ? ST_SCAN : ST_GUARD;
        end
      end
      default: ;
    endcase
    // A fresh SCAN slot for digit 0 marks the frame boundary (covers the GUARD == 0 back-to-back case).
    snap = (state_nx == ST_SCAN) && (idx_nx == '0) &&
           (state == ST_GUARD || cnt == DWELL_LAST);
  end

  // Outputs are registered from next-state, so the snapshot cycle must bypass the shadow regs.
  assign in_sel  = 3'(idx_nx);
  assign code_nx = snap ? in_vec[in_sel] : shadow[idx_nx];

  seg7_decode u_decode (
    .code  (code_nx),
    .blank (blank_nx),
    .seg_n (seg_nx)
  );

`ifdef SEG7_SCAN_DIMMING_EN
  logic [2:0] bright_q;
  logic [2:0] bright_nx;

  assign bright_nx = snap ? bright : bright_q;
  assign in_window = (32'(cnt_nx) < (DWELL >> 3) * (32'(bright_nx) + 32'd1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bright_q <= '0;
    end else if (snap) begin
      bright_q <= bright;
    end
  end
`else
  logic unused_bright;
  assign unused_bright = ^bright;
  assign in_window     = 1'b1;
`endif

  assign lit_nx = (state_nx == ST_SCAN) && !blank_nx && in_window;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_GUARD;
      cnt        <= '0;
      idx        <= '0;
      an_n       <= '1;
      seg_n      <= SEG_OFF;
      frame_tick <= 1'b0;
      for (int unsigned i = 0; i < D; i++) begin
        shadow[i] <= CODE_BLANK;
      end
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      idx        <= idx_nx;
      frame_tick <= snap;
      if (snap) begin
        for (int unsigned i = 0; i < D; i++) begin
          shadow[i] <= in_vec[i];
        end
      end
      an_n  <= lit_nx ? ~(D'(1) << idx_nx) : '1;
      seg_n <= lit_nx ? seg_nx : SEG_OFF;
    end
  end

endmodule
